// File: rtl/fetch_if.sv
// Instruction-fetch boundary: instruction-bus request/response, decode back-pressure,
// redirect input and the fetch/decode register outputs.
interface fetch_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    modport master (
        output ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        input  iresp_data_ok, iresp_data, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        output iresp_data_ok, iresp_data, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues 32-bit reads, feeds decode through one
// output register plus a one-entry overflow buffer, and squashes on redirect.
module fetch #(
    parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state_q;
    logic [63:0] req_pc_q;
    logic [63:0] next_pc_q;
    logic        pend_valid_q;
    logic [63:0] pend_pc_q;
    logic [31:0] pend_instr_q;
    logic        out_valid_q;
    logic [63:0] out_pc_q;
    logic [31:0] out_instr_q;

    logic        out_free;
    logic [63:0] redir_tgt_d;

    assign out_free    = !out_valid_q || !bus.stall;
    assign redir_tgt_d = bus.redirect_pc & ~64'h3;

    assign bus.ireq_valid = (state_q == FETCH || state_q == DISCARD) && !reset;
    assign bus.ireq_addr  = req_pc_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = out_pc_q;
    assign bus.out_instr  = out_instr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            req_pc_q     <= PCINIT;
            next_pc_q    <= PCINIT + 64'd4;
            pend_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
        end else if (bus.redirect_valid) begin
            out_valid_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            // The request stays on the bus until its data returns, so only the
            // follow-on address can be retargeted while it is outstanding.
            if (state_q != HOLD && !bus.iresp_data_ok) begin
                next_pc_q <= redir_tgt_d;
                state_q   <= DISCARD;
            end else begin
                req_pc_q  <= redir_tgt_d;
                next_pc_q <= redir_tgt_d + 64'd4;
                state_q   <= FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.iresp_data_ok) begin
                        req_pc_q  <= next_pc_q;
                        next_pc_q <= next_pc_q + 64'd4;
                        if (out_free) begin
                            out_valid_q <= 1'b1;
                            out_pc_q    <= req_pc_q;
                            out_instr_q <= bus.iresp_data;
                        end else begin
                            pend_valid_q <= 1'b1;
                            pend_pc_q    <= req_pc_q;
                            pend_instr_q <= bus.iresp_data;
                            state_q      <= HOLD;
                        end
                    end else if (out_free) begin
                        out_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_free && pend_valid_q) begin
                        out_valid_q  <= 1'b1;
                        out_pc_q     <= pend_pc_q;
                        out_instr_q  <= pend_instr_q;
                        pend_valid_q <= 1'b0;
                        state_q      <= FETCH;
                    end
                end
                DISCARD: begin
                    if (out_free) out_valid_q <= 1'b0;
                    if (bus.iresp_data_ok) begin
                        req_pc_q  <= next_pc_q;
                        next_pc_q <= next_pc_q + 64'd4;
                        state_q   <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: one instance at the default PCINIT, one at the top of the
// address space to exercise PC wrap.
module tb_fetch;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fetch_if bus_a ();
    fetch_if bus_b ();

    fetch #(.PCINIT(64'h0000_0000_8000_0000)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.master));
    fetch #(.PCINIT(64'hFFFF_FFFF_FFFF_FFFC)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.master));

    always #5 clk = ~clk;

    // Memory contents: each word is its address plus 0x1000_0000 (low 32 bits).
    function automatic logic [31:0] word(input logic [63:0] pc);
        return pc[31:0] + 32'h1000_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_v, input logic dok, input logic st,
                        input logic rv, input logic [63:0] rpc);
        reset                = rst_v;
        bus_a.iresp_data_ok  = dok;
        bus_a.stall          = st;
        bus_a.redirect_valid = rv;
        bus_a.redirect_pc    = rpc;
        @(posedge clk);
        #1;
        bus_a.iresp_data = word(bus_a.ireq_addr);
        bus_b.iresp_data = word(bus_b.ireq_addr);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk   = 1'b0;
        reset = 1'b1;
        bus_a.iresp_data_ok  = 1'b0;
        bus_a.iresp_data     = '0;
        bus_a.stall          = 1'b0;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = '0;
        bus_b.iresp_data_ok  = 1'b1;
        bus_b.iresp_data     = '0;
        bus_b.stall          = 1'b0;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = '0;

        step(1, 0, 0, 0, 64'h0);
        step(1, 0, 0, 0, 64'h0);
        chk("rst_out_valid",  64'(bus_a.out_valid),  64'h0);
        chk("rst_out_pc",     bus_a.out_pc,          64'h0);
        chk("rst_out_instr",  64'(bus_a.out_instr),  64'h0);
        chk("rst_ireq_valid", 64'(bus_a.ireq_valid), 64'h0);
        chk("rst_ireq_addr",  bus_a.ireq_addr,       64'h0000_0000_8000_0000);

        // Zero-latency memory, back-to-back issue; wrap instance runs alongside.
        step(0, 1, 0, 0, 64'h0);
        chk("zl0_valid", 64'(bus_a.out_valid), 64'h1);
        chk("zl0_pc",    bus_a.out_pc,         64'h0000_0000_8000_0000);
        chk("zl0_instr", 64'(bus_a.out_instr), 64'h9000_0000);
        chk("wrap0_pc",  bus_b.out_pc,         64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap0_ins", 64'(bus_b.out_instr), 64'h0FFF_FFFC);
        step(0, 1, 0, 0, 64'h0);
        chk("zl1_pc",    bus_a.out_pc,         64'h0000_0000_8000_0004);
        chk("wrap1_pc",  bus_b.out_pc,         64'h0);
        chk("wrap1_ins", 64'(bus_b.out_instr), 64'h1000_0000);
        step(0, 1, 0, 0, 64'h0);
        chk("zl2_pc",    bus_a.out_pc,         64'h0000_0000_8000_0008);
        chk("zl2_instr", 64'(bus_a.out_instr), 64'h9000_0008);
        chk("wrap2_pc",  bus_b.out_pc,         64'h4);

        // Three-cycle latency on the request to 8000_000C.
        step(0, 0, 0, 0, 64'h0);
        chk("lat_valid0", 64'(bus_a.out_valid),  64'h0);
        chk("lat_req0",   64'(bus_a.ireq_valid), 64'h1);
        chk("lat_addr0",  bus_a.ireq_addr,       64'h0000_0000_8000_000C);
        step(0, 0, 0, 0, 64'h0);
        chk("lat_addr1",  bus_a.ireq_addr,       64'h0000_0000_8000_000C);
        step(0, 1, 0, 0, 64'h0);
        chk("lat_valid",  64'(bus_a.out_valid),  64'h1);
        chk("lat_pc",     bus_a.out_pc,          64'h0000_0000_8000_000C);
        chk("lat_instr",  64'(bus_a.out_instr),  64'h9000_000C);
        chk("lat_next",   bus_a.ireq_addr,       64'h0000_0000_8000_0010);
        step(0, 0, 0, 0, 64'h0);
        chk("lat_pulse",  64'(bus_a.out_valid),  64'h0);

        // Stall for four cycles while the next word arrives.
        step(0, 1, 0, 0, 64'h0);
        chk("st_load_pc", bus_a.out_pc,          64'h0000_0000_8000_0010);
        step(0, 1, 1, 0, 64'h0);
        chk("st_hold_pc", bus_a.out_pc,          64'h0000_0000_8000_0010);
        chk("st_noreq",   64'(bus_a.ireq_valid), 64'h0);
        step(0, 0, 1, 0, 64'h0);
        step(0, 0, 1, 0, 64'h0);
        step(0, 0, 1, 0, 64'h0);
        chk("st_end_pc",  bus_a.out_pc,          64'h0000_0000_8000_0010);
        chk("st_end_vld", 64'(bus_a.out_valid),  64'h1);
        chk("st_end_req", 64'(bus_a.ireq_valid), 64'h0);
        step(0, 0, 0, 0, 64'h0);
        chk("st_pend_pc", bus_a.out_pc,          64'h0000_0000_8000_0014);
        chk("st_pend_in", 64'(bus_a.out_instr),  64'h9000_0014);
        chk("st_resume",  bus_a.ireq_addr,       64'h0000_0000_8000_0018);
        chk("st_req_on",  64'(bus_a.ireq_valid), 64'h1);
        step(0, 1, 0, 0, 64'h0);
        chk("st_after",   bus_a.out_pc,          64'h0000_0000_8000_0018);

        // Redirect while the request to 8000_001C is outstanding.
        step(0, 0, 0, 0, 64'h0);
        chk("rd_drain",   64'(bus_a.out_valid),  64'h0);
        step(0, 0, 0, 1, 64'h0000_0000_8000_0100);
        chk("rd_valid",   64'(bus_a.out_valid),  64'h0);
        chk("rd_stale",   bus_a.ireq_addr,       64'h0000_0000_8000_001C);
        chk("rd_streq",   64'(bus_a.ireq_valid), 64'h1);
        step(0, 1, 0, 0, 64'h0);
        chk("rd_drop",    64'(bus_a.out_valid),  64'h0);
        chk("rd_target",  bus_a.ireq_addr,       64'h0000_0000_8000_0100);
        step(0, 1, 0, 0, 64'h0);
        chk("rd_pc",      bus_a.out_pc,          64'h0000_0000_8000_0100);
        chk("rd_instr",   64'(bus_a.out_instr),  64'h9000_0100);

        // Redirect to an unaligned target together with data_ok and stall.
        step(0, 1, 1, 1, 64'h0000_0000_8000_0203);
        chk("ru_valid",   64'(bus_a.out_valid),  64'h0);
        chk("ru_addr",    bus_a.ireq_addr,       64'h0000_0000_8000_0200);
        step(0, 1, 0, 0, 64'h0);
        chk("ru_pc",      bus_a.out_pc,          64'h0000_0000_8000_0200);

        // Redirect taken from HOLD squashes the buffered word.
        step(0, 1, 1, 0, 64'h0);
        chk("rh_hold",    64'(bus_a.ireq_valid), 64'h0);
        step(0, 0, 1, 1, 64'h0000_0000_8000_0300);
        chk("rh_valid",   64'(bus_a.out_valid),  64'h0);
        chk("rh_addr",    bus_a.ireq_addr,       64'h0000_0000_8000_0300);
        step(0, 1, 0, 0, 64'h0);
        chk("rh_pc",      bus_a.out_pc,          64'h0000_0000_8000_0300);

        // Reset during a stall with a request outstanding.
        step(0, 0, 1, 0, 64'h0);
        chk("mr_pre",     bus_a.ireq_addr,       64'h0000_0000_8000_0304);
        step(1, 1, 1, 0, 64'h0);
        chk("mr_valid",   64'(bus_a.out_valid),  64'h0);
        chk("mr_req",     64'(bus_a.ireq_valid), 64'h0);
        chk("mr_addr",    bus_a.ireq_addr,       64'h0000_0000_8000_0000);
        step(0, 1, 0, 0, 64'h0);
        chk("mr_pc",      bus_a.out_pc,          64'h0000_0000_8000_0000);
        chk("mr_instr",   64'(bus_a.out_instr),  64'h9000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
